// File: rtl/cm_ram_arb_pkg.sv
// Shared types, constants and helpers for the RAM port arbiter.
// Request ids are carried alongside reads so the data returns to the right client.
package cm_ram_arb_pkg;

  localparam int unsigned MAX_NUM = 8;
  localparam int unsigned ID_W    = 3;
  localparam int unsigned RAM_AW  = 16;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } rsp_tag_t;

  // Next round-robin position; wraps explicitly so non-power-of-two NUM is safe.
  function automatic logic [ID_W-1:0] rr_next(input logic [ID_W-1:0] ptr,
                                              input int unsigned     num);
    if (ptr >= ID_W'(num - 1)) return '0;
    return ptr + ID_W'(1);
  endfunction

endpackage

// File: rtl/cm_ram_port_arbiter_if.sv
// Client request/response bus plus the RAM A-port bus of the arbiter.
// The slave modport is the arbiter; the master modport is the client/RAM side.
interface cm_ram_port_arbiter_if
  import cm_ram_arb_pkg::*;
#(
  parameter int unsigned NUM   = 4,
  parameter int unsigned DSIZE = 18,
  parameter int unsigned RSIZE = 10,
  parameter int unsigned MSIZE = 1
);

  logic [NUM-1:0]       req_vld;
  logic [NUM-1:0]       req_rdy;
  logic [NUM-1:0]       req_we;
  logic [NUM*RSIZE-1:0] req_addr;
  logic [NUM*DSIZE-1:0] req_wdata;
  logic [NUM*MSIZE-1:0] req_wmask;
  logic [NUM-1:0]       rsp_vld;
  logic [DSIZE-1:0]     rsp_data;

  logic                 ram_clka;
  logic                 ram_rsta;
  logic                 ram_ena;
  logic [RAM_AW-1:0]    ram_addra;
  logic [DSIZE-1:0]     ram_dia;
  logic [MSIZE-1:0]     ram_wea;
  logic [DSIZE-1:0]     ram_doa;

  modport slave (
    input  req_vld, req_we, req_addr, req_wdata, req_wmask, ram_doa,
    output req_rdy, rsp_vld, rsp_data,
           ram_clka, ram_rsta, ram_ena, ram_addra, ram_dia, ram_wea
  );

  modport master (
    output req_vld, req_we, req_addr, req_wdata, req_wmask, ram_doa,
    input  req_rdy, rsp_vld, rsp_data,
           ram_clka, ram_rsta, ram_ena, ram_addra, ram_dia, ram_wea
  );

endinterface

// File: rtl/cm_ram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, search starting after the last winner.
// The pointer only moves when the grant is actually taken (adv_i).
module rr_arbiter
  import cm_ram_arb_pkg::*;
#(
  parameter int unsigned NUM = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NUM-1:0]  req_i,
  input  logic            adv_i,
  output logic [NUM-1:0]  gnt_c_o,
  output logic [ID_W-1:0] gnt_id_c_o
);

  logic [ID_W-1:0] ptr_q;
  logic [ID_W-1:0] ptr_d;
  logic [ID_W-1:0] start_c;
  logic            found_c;

  // Two passes over constant indices: [start..NUM-1] then [0..start-1].
  always_comb begin
    start_c    = rr_next(ptr_q, NUM);
    gnt_c_o    = '0;
    gnt_id_c_o = '0;
    found_c    = 1'b0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!found_c && req_i[i] && (ID_W'(i) >= start_c)) begin
        found_c    = 1'b1;
        gnt_c_o[i] = 1'b1;
        gnt_id_c_o = ID_W'(i);
      end
    end
    for (int unsigned i = 0; i < NUM; i++) begin
      if (!found_c && req_i[i] && (ID_W'(i) < start_c)) begin
        found_c    = 1'b1;
        gnt_c_o[i] = 1'b1;
        gnt_id_c_o = ID_W'(i);
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && found_c) ptr_d = gnt_id_c_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= ID_W'(NUM - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/cm_ram_port_arbiter.sv
// Shares one RAM A-port among NUM requesters with round-robin arbitration.
// Reads return through a tag pipeline matched to the RAM latency plus one output register.
module cm_ram_port_arbiter
  import cm_ram_arb_pkg::*;
#(
  parameter int unsigned NUM    = 4,
  parameter int unsigned DSIZE  = 18,
  parameter int unsigned RSIZE  = 10,
  parameter int unsigned MSIZE  = 1,
  parameter int unsigned RD_LAT = 2
) (
  input logic                  clock,
  input logic                  rst_n,
  cm_ram_port_arbiter_if.slave bus
);

  logic [NUM-1:0]    gnt_c;
  logic [ID_W-1:0]   gnt_id_c;
  logic              accept_c;
  logic              sel_we_c;
  logic [RSIZE-1:0]  sel_addr_c;
  logic [DSIZE-1:0]  sel_wdata_c;
  logic [MSIZE-1:0]  sel_wmask_c;

  logic              ena_q,   ena_d;
  logic [RAM_AW-1:0] addra_q, addra_d;
  logic [DSIZE-1:0]  dia_q,   dia_d;
  logic [MSIZE-1:0]  wea_q,   wea_d;

  rsp_tag_t          tag_q [RD_LAT+1];
  rsp_tag_t          tag_d;
  logic [NUM-1:0]    rsp_vld_q,  rsp_vld_d;
  logic [DSIZE-1:0]  rsp_data_q, rsp_data_d;

  rr_arbiter #(.NUM(NUM)) u_rr (
    .clk        (clock),
    .rst_n      (rst_n),
    .req_i      (bus.req_vld),
    .adv_i      (accept_c),
    .gnt_c_o    (gnt_c),
    .gnt_id_c_o (gnt_id_c)
  );

  assign accept_c     = |(bus.req_vld & gnt_c);
  assign bus.req_rdy  = gnt_c;
  assign bus.ram_clka = clock;
  assign bus.ram_rsta = ~rst_n;

  // One-hot grant steers the winning requester's fields.
  always_comb begin
    sel_we_c    = 1'b0;
    sel_addr_c  = '0;
    sel_wdata_c = '0;
    sel_wmask_c = '0;
    for (int unsigned i = 0; i < NUM; i++) begin
      if (gnt_c[i]) begin
        sel_we_c    = bus.req_we[i];
        sel_addr_c  = bus.req_addr[i*RSIZE +: RSIZE];
        sel_wdata_c = bus.req_wdata[i*DSIZE +: DSIZE];
        sel_wmask_c = bus.req_wmask[i*MSIZE +: MSIZE];
      end
    end
  end

  always_comb begin
    ena_d      = accept_c;
    wea_d      = (accept_c && sel_we_c) ? sel_wmask_c : '0;
    addra_d    = accept_c ? RAM_AW'(sel_addr_c) : addra_q;
    dia_d      = accept_c ? sel_wdata_c : dia_q;
    tag_d.vld  = accept_c && !sel_we_c;
    tag_d.id   = gnt_id_c;
    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (tag_q[RD_LAT].vld) begin
      rsp_vld_d  = NUM'(1) << tag_q[RD_LAT].id;
      rsp_data_d = bus.ram_doa;
    end
  end

  // Async reset drops in-flight tags and kills ena/wea at once.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      ena_q      <= 1'b0;
      addra_q    <= '0;
      dia_q      <= '0;
      wea_q      <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      for (int unsigned k = 0; k <= RD_LAT; k++) tag_q[k] <= '0;
    end else begin
      ena_q      <= ena_d;
      addra_q    <= addra_d;
      dia_q      <= dia_d;
      wea_q      <= wea_d;
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      tag_q[0]   <= tag_d;
      for (int unsigned k = 1; k <= RD_LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign bus.ram_ena   = ena_q;
  assign bus.ram_addra = addra_q;
  assign bus.ram_dia   = dia_q;
  assign bus.ram_wea   = wea_q;
  assign bus.rsp_vld   = rsp_vld_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cm_ram_port_arbiter.sv
// Directed plus randomized bench for cm_ram_port_arbiter with a behavioural RAM and
// a reference model built from the round-robin/latency rules.
module tb_cm_ram_port_arbiter;

  localparam int unsigned NUM    = 4;
  localparam int unsigned DSIZE  = 18;
  localparam int unsigned RSIZE  = 10;
  localparam int unsigned MSIZE  = 1;
  localparam int unsigned RD_LAT = 2;

  logic clk;
  logic rst_n;

  cm_ram_port_arbiter_if #(.NUM(NUM), .DSIZE(DSIZE), .RSIZE(RSIZE), .MSIZE(MSIZE)) bus ();

  cm_ram_port_arbiter #(
    .NUM(NUM), .DSIZE(DSIZE), .RSIZE(RSIZE), .MSIZE(MSIZE), .RD_LAT(RD_LAT)
  ) dut (
    .clock (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: read-first, data valid RD_LAT cycles after ena.
  logic [DSIZE-1:0] ram_mem [0:(1<<RSIZE)-1];
  logic [DSIZE-1:0] rd_pipe [RD_LAT];
  assign bus.ram_doa = rd_pipe[RD_LAT-1];
  always @(posedge clk) begin
    if (bus.ram_ena) begin
      if (bus.ram_wea[0]) ram_mem[bus.ram_addra[RSIZE-1:0]] <= bus.ram_dia;
      rd_pipe[0] <= ram_mem[bus.ram_addra[RSIZE-1:0]];
    end
    for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  typedef struct {
    int unsigned      due;
    int               id;
    logic [DSIZE-1:0] data;
  } exp_rsp_t;

  int               checks;
  int               errors;
  int unsigned      cyc;
  int               m_ptr;
  logic             m_ena;
  logic [15:0]      m_addra;
  logic [DSIZE-1:0] m_dia;
  logic [MSIZE-1:0] m_wea;
  logic [DSIZE-1:0] ref_mem [0:(1<<RSIZE)-1];
  exp_rsp_t         rq [$];

  logic [NUM-1:0]   last_rdy;
  logic [NUM-1:0]   last_rsp_vld;
  logic [DSIZE-1:0] last_rsp_data;
  logic             last_ena;
  logic [15:0]      last_addra;
  logic [DSIZE-1:0] last_dia;
  logic [MSIZE-1:0] last_wea;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic idle();
    bus.req_vld   = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
  endtask

  task automatic set_req(input int i, input logic vld, input logic we,
                         input logic [RSIZE-1:0] addr, input logic [DSIZE-1:0] wd,
                         input logic [MSIZE-1:0] wm);
    bus.req_vld[i]                   = vld;
    bus.req_we[i]                    = we;
    bus.req_addr[i*RSIZE +: RSIZE]   = addr;
    bus.req_wdata[i*DSIZE +: DSIZE]  = wd;
    bus.req_wmask[i*MSIZE +: MSIZE]  = wm;
  endtask

  // One clock cycle: check all outputs mid-cycle, then advance the reference model.
  task automatic step();
    int               g;
    logic [NUM-1:0]   v;
    logic [NUM-1:0]   exp_rdy;
    logic [NUM-1:0]   exp_vld;
    logic [RSIZE-1:0] a;
    logic [DSIZE-1:0] wd;
    logic [MSIZE-1:0] wm;
    logic             we;
    exp_rsp_t         e;
    @(negedge clk);
    v = bus.req_vld;
    g = -1;
    for (int k = 1; k <= NUM; k++) begin
      int idx;
      idx = (m_ptr + k) % NUM;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    chk("ram_ena", 32'(bus.ram_ena), 32'(m_ena));
    chk("ram_wea", 32'(bus.ram_wea), 32'(m_wea));
    chk("ram_addra", 32'(bus.ram_addra), 32'(m_addra));
    chk("ram_dia", 32'(bus.ram_dia), 32'(m_dia));
    chk("ram_rsta", 32'(bus.ram_rsta), 32'd0);
    if (rq.size() > 0 && rq[0].due == cyc) begin
      e = rq.pop_front();
      exp_vld = '0;
      exp_vld[e.id] = 1'b1;
      chk("rsp_vld", 32'(bus.rsp_vld), 32'(exp_vld));
      chk("rsp_data", 32'(bus.rsp_data), 32'(e.data));
    end else begin
      chk("rsp_vld_idle", 32'(bus.rsp_vld), 32'd0);
    end
    last_rdy      = bus.req_rdy;
    last_rsp_vld  = bus.rsp_vld;
    last_rsp_data = bus.rsp_data;
    last_ena      = bus.ram_ena;
    last_addra    = bus.ram_addra;
    last_dia      = bus.ram_dia;
    last_wea      = bus.ram_wea;
    if (g >= 0) begin
      a  = bus.req_addr[g*RSIZE +: RSIZE];
      wd = bus.req_wdata[g*DSIZE +: DSIZE];
      wm = bus.req_wmask[g*MSIZE +: MSIZE];
      we = bus.req_we[g];
      m_ena   = 1'b1;
      m_addra = 16'(a);
      m_dia   = wd;
      m_wea   = we ? wm : '0;
      if (we) begin
        if (wm[0]) ref_mem[a] = wd;
      end else begin
        e.due  = cyc + RD_LAT + 2;
        e.id   = g;
        e.data = ref_mem[a];
        rq.push_back(e);
      end
      m_ptr = g;
    end else begin
      m_ena = 1'b0;
      m_wea = '0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_rsta", 32'(bus.ram_rsta), 32'd1);
    chk("rst_ena", 32'(bus.ram_ena), 32'd0);
    chk("rst_wea", 32'(bus.ram_wea), 32'd0);
    chk("rst_addra", 32'(bus.ram_addra), 32'd0);
    chk("rst_dia", 32'(bus.ram_dia), 32'd0);
    chk("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
    chk("rst_rdy", 32'(bus.req_rdy), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_hold_rsp_vld", 32'(bus.rsp_vld), 32'd0);
      chk("rst_hold_ena", 32'(bus.ram_ena), 32'd0);
      chk("ram_clka", 32'(bus.ram_clka), 32'(clk));
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_ptr   = NUM - 1;
    m_ena   = 1'b0;
    m_wea   = '0;
    m_addra = '0;
    m_dia   = '0;
    rq.delete();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rst_n  = 1'b1;
    idle();
    #2;
    do_reset();

    // Idle after reset: nothing enabled
    repeat (10) step();
    chk("idle_ena", 32'(last_ena), 32'd0);

    // Requester 2 writes 0x2A5A5 to addr 5
    set_req(2, 1'b1, 1'b1, 10'h005, 18'h2A5A5, 1'b1);
    step();
    chk("wr_gnt", 32'(last_rdy), 32'b0100);
    idle();
    step();
    chk("wr_ena", 32'(last_ena), 32'd1);
    chk("wr_addra", 32'(last_addra), 32'h0005);
    chk("wr_dia", 32'(last_dia), 32'h2A5A5);
    chk("wr_wea", 32'(last_wea), 32'd1);
    repeat (4) step();

    // Requester 1 reads addr 5 back
    set_req(1, 1'b1, 1'b0, 10'h005, '0, '0);
    step();
    chk("rd_gnt", 32'(last_rdy), 32'b0010);
    idle();
    step();
    chk("rd_ena", 32'(last_ena), 32'd1);
    chk("rd_wea", 32'(last_wea), 32'd0);
    repeat (3) step();
    chk("rd_rsp_vld", 32'(last_rsp_vld), 32'b0010);
    chk("rd_rsp_data", 32'(last_rsp_data), 32'h2A5A5);
    repeat (2) step();

    // All four reading continuously from reset: rotation 0,1,2,3,...
    do_reset();
    for (int i = 0; i < NUM; i++) set_req(i, 1'b1, 1'b0, 10'h005, '0, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      chk("rot_gnt", 32'(last_rdy), 32'(1 << (k % NUM)));
    end
    idle();
    repeat (6) step();

    // Requesters 0 and 3; 0 drops after one grant, later returns
    set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
    set_req(3, 1'b1, 1'b0, 10'h005, '0, '0);
    step();
    chk("pair_gnt0", 32'(last_rdy), 32'b0001);
    set_req(0, 1'b0, 1'b0, '0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pair_gnt3", 32'(last_rdy), 32'b1000);
    end
    set_req(0, 1'b1, 1'b0, 10'h005, '0, '0);
    step();
    chk("pair_wrap", 32'(last_rdy), 32'b0001);
    idle();
    repeat (6) step();

    // Reset lands on two in-flight reads; they must never respond
    set_req(2, 1'b1, 1'b0, 10'h005, '0, '0);
    step();
    step();
    do_reset();
    set_req(1, 1'b1, 1'b1, 10'h007, 18'h01234, 1'b1);
    set_req(3, 1'b1, 1'b1, 10'h008, 18'h04321, 1'b1);
    step();
    chk("post_rst_gnt", 32'(last_rdy), 32'b0010);
    idle();
    repeat (8) step();

    // Preload the random address window
    for (int a = 0; a < 16; a++) begin
      idle();
      set_req(a % NUM, 1'b1, 1'b1, RSIZE'(a), DSIZE'($urandom), 1'b1);
      step();
    end

    // Random traffic against the reference model
    repeat (400) begin
      for (int i = 0; i < NUM; i++)
        set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                RSIZE'($urandom_range(0, 15)), DSIZE'($urandom),
                MSIZE'($urandom_range(0, 3) != 0));
      step();
    end
    idle();
    repeat (8) step();
    chk("drain_empty", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cm_ram_port_arbiter.md
Name: cm_ram_port_arbiter

Overview:
- Shares one RAM port (A side: clka/rsta/ena/addra/dia/wea/doa) between NUM independent requesters.
- Round-robin arbitration, one access per cycle, registered RAM drive.
- Read data is returned to the originating requester through a latency-matched tag pipeline.
- Sits between client logic (DMA readers, table lookups) and a cm_ram_inf master_A modport.

Parameters:
- NUM, 4, number of requesters (2..8).
- DSIZE, 18, data width.
- RSIZE, 10, address width presented by requesters; zero-extended to the 16-bit RAM address.
- MSIZE, 1, write-enable mask width.
- RD_LAT, 2, RAM read latency in cycles from registered ena/addra to valid doa (1..4).

Ports:
- clock  input  1  block clock; also forwarded to RAM.
- rst_n  input  1  asynchronous active-low reset.
- req_vld  input  NUM  per-requester request valid.
- req_rdy  output  NUM  per-requester accept (one-hot or zero).
- req_we  input  NUM  1 = write, 0 = read.
- req_addr  input  NUM*RSIZE  packed addresses, requester i at [i*RSIZE +: RSIZE].
- req_wdata  input  NUM*DSIZE  packed write data.
- req_wmask  input  NUM*MSIZE  packed write byte-enables.
- rsp_vld  output  NUM  read response valid, single-cycle pulse, no backpressure.
- rsp_data  output  DSIZE  read data, shared bus, qualified by rsp_vld.
- ram_clka  output  1  equals clock.
- ram_rsta  output  1  equals ~rst_n (combinational).
- ram_ena  output  1  registered RAM enable.
- ram_addra  output  16  registered address.
- ram_dia  output  DSIZE  registered write data.
- ram_wea  output  MSIZE  registered write mask.
- ram_doa  input  DSIZE  RAM read data.

Behaviour:
- Reset values: req_rdy, rsp_vld, ram_ena, ram_addra, ram_dia, ram_wea all 0; rsp_data 0; RR pointer = NUM-1, so requester 0 has top priority first.
- Grant is combinational from req_vld and the RR pointer. Search starts at pointer+1 and wraps modulo NUM. req_rdy is one-hot on the winner; it is 0 when no requester is valid.
- A request is accepted in cycle t when req_vld[i] & req_rdy[i]. On acceptance the pointer becomes i; otherwise the pointer holds.
- Cycle t+1 RAM drive:
  - ram_ena = 1.
  - ram_addra = zero-extended addr.
  - ram_dia = wdata.
  - ram_wea = wmask if we, else 0.
- With no acceptance in t: ram_ena = 0 and ram_wea = 0 in t+1; addra/dia hold.
- Reads: tag pipeline of RD_LAT+1 stages carrying {valid, id}. rsp_vld[id] pulses in cycle t+RD_LAT+2 with rsp_data = ram_doa registered. At most one rsp_vld bit is high per cycle.
- Writes produce no response.
- Throughput is one access per cycle. Back-to-back mixed reads/writes keep acceptance order. Same-address read-after-write ordering follows RAM port semantics; the arbiter does not reorder.
- Single active requester: granted every cycle it is valid.
- All NUM requesters continuously valid: grants rotate 0,1,...,NUM-1,0. No requester waits more than NUM-1 cycles.
- req_vld dropped without acceptance: permitted, no side effect.
- Asynchronous reset mid-operation:
  - Tag pipeline cleared; in-flight reads are dropped with no rsp_vld.
  - ram_ena/ram_wea forced to 0 immediately, so no partial write is issued after reset asserts.
  - Pointer returns to NUM-1.
- A requester index outside 0..NUM-1 cannot occur; grant logic must be safe when NUM is not a power of two.

Decomposition:
- Package cm_ram_arb_pkg holds:
  - rsp_tag_t struct {logic vld; logic [2:0] id;}
  - constant MAX_NUM = 8
  - function rr_next(ptr, NUM)
- Sub-module rr_arbiter #(NUM): inputs req[NUM] and adv; outputs one-hot gnt[NUM] and gnt_id. Combinational grant with a registered pointer on async rst_n.
- Top level handles the mux, RAM registers and tag pipeline.

Test Plan:
- Reset then idle → all outputs 0, ram_rsta = 1 while rst_n = 0, ram_ena = 0 for 10 cycles after release.
- Requester 2 alone writes addr 0x05, data 0x2A5A5, mask 1 at t → req_rdy = 0100 at t; ram_ena = 1, addra = 0x0005, dia = 0x2A5A5, wea = 1 at t+1; no rsp.
- Requester 1 reads addr 0x05 at t (RD_LAT = 2) → ram_ena = 1, wea = 0 at t+1; rsp_vld = 0010 with rsp_data = 0x2A5A5 at t+4.
- All four valid reads for 8 cycles from reset → grant order 0,1,2,3,0,1,2,3; rsp_vld pulses in the same order, each 4 cycles after its grant.
- Requesters 0 and 3 valid, 0 drops after one grant → grants 0,3,3,3; pointer wraps correctly from 3 to 0 when 0 reasserts.
- rst_n pulsed low at t+2 after two reads issued at t, t+1 → no rsp_vld ever for those reads; next grant after release goes to the lowest-index valid requester.
